// File: rtl/aurora_link_pkg.sv
// aurora_link_pkg: shared types and constants for the Aurora link init sequencer.
package aurora_link_pkg;
    typedef enum logic [2:0] {
        ST_PMA_ASSERT = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_WAIT_UP    = 3'd2,
        ST_LINKED     = 3'd3,
        ST_BACKOFF    = 3'd4,
        ST_FAILED     = 3'd5
    } state_e;

    localparam int BACKOFF_MAX_SHIFT = 4;
    localparam int DROP_W            = 16;

    function automatic int backoff_shift(input int retries);
        return (retries > BACKOFF_MAX_SHIFT) ? BACKOFF_MAX_SHIFT : retries;
    endfunction
endpackage

// File: rtl/aurora_sync_bit.sv
// aurora_sync_bit: multi-flop single-bit synchroniser with asynchronous clear.
module aurora_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/aurora_link_init_ctrl.sv
// aurora_link_init_ctrl: power-on/recovery sequencer for an N-lane Aurora 64b66b link;
// orders pma_init/reset_pb, waits for channel-up with timeout and retries with backoff.
module aurora_link_init_ctrl
    import aurora_link_pkg::*;
#(
    parameter int N_LANES          = 4,
    parameter int PMA_PULSE_CYCLES = 16777215,
    parameter int RESET_PB_HOLD    = 128,
    parameter int LINK_TIMEOUT     = 100000000,
    parameter int MAX_RETRIES      = 8,
    parameter int BACKOFF_BASE     = 1024,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                             INIT_CLK_IN,
    input  logic                             RESET_N,
    input  logic                             PMA_INIT,
    input  logic                             CHANNEL_UP,
    input  logic [N_LANES-1:0]               LANE_UP,
    input  logic                             HARD_ERR,
    input  logic                             AUTO_RETRY_EN,
    output logic                             pma_init_o,
    output logic                             reset_pb_o,
    output logic                             link_ok,
    output logic                             link_failed,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [DROP_W-1:0]                drop_cnt,
    output logic [2:0]                       state_o
);
    localparam int RW     = $clog2(MAX_RETRIES + 1);
    localparam int BO_MAX = BACKOFF_BASE << BACKOFF_MAX_SHIFT;
    localparam int MAX_A  = (PMA_PULSE_CYCLES > RESET_PB_HOLD) ? PMA_PULSE_CYCLES : RESET_PB_HOLD;
    localparam int MAX_B  = (LINK_TIMEOUT > BO_MAX) ? LINK_TIMEOUT : BO_MAX;
    localparam int MAX_D  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW     = $clog2(MAX_D + 1);

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic                   rst_n_i;
    logic                   ch_s, hard_s, pma_s, manual, all_up, go;
    logic [N_LANES-1:0]     lane_s;
    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d, bo_last;
    logic [RW-1:0]          retry_q, retry_d, retry_inc;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic                   down_q, down_d, pma_prev_q, pma_prev_d;
    logic                   pma_q, pma_d, rpb_q, rpb_d, ok_q, ok_d, fail_q, fail_d;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_comb rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge INIT_CLK_IN or negedge RESET_N) begin
        if (!RESET_N) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n_i = rst_sync_q[SYNC_STAGES-1];

    aurora_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ch (
        .clk(INIT_CLK_IN), .rst_n(rst_n_i), .d(CHANNEL_UP), .q(ch_s));
    aurora_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_hard (
        .clk(INIT_CLK_IN), .rst_n(rst_n_i), .d(HARD_ERR), .q(hard_s));
    aurora_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_pma (
        .clk(INIT_CLK_IN), .rst_n(rst_n_i), .d(PMA_INIT), .q(pma_s));

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        aurora_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lane (
            .clk(INIT_CLK_IN), .rst_n(rst_n_i), .d(LANE_UP[i]), .q(lane_s[i]));
    end

    always_comb begin
        manual     = pma_s & ~pma_prev_q;
        all_up     = ch_s & (&lane_s);
        retry_inc  = (retry_q == RW'(MAX_RETRIES)) ? retry_q : retry_q + 1'b1;
        bo_last    = TW'((BACKOFF_BASE << backoff_shift(int'(retry_q))) - 1);
        state_d    = state_q;
        retry_d    = retry_q;
        drop_d     = drop_q;
        go         = 1'b0;
        if (manual) begin
            state_d = ST_PMA_ASSERT;
            retry_d = '0;
            go      = 1'b1;
        end else begin
            case (state_q)
                ST_PMA_ASSERT: if (timer_q == TW'(PMA_PULSE_CYCLES - 1)) begin
                    state_d = ST_RESET_HOLD;
                    go      = 1'b1;
                end
                ST_RESET_HOLD: if (timer_q == TW'(RESET_PB_HOLD - 1)) begin
                    state_d = ST_WAIT_UP;
                    go      = 1'b1;
                end
                ST_WAIT_UP: if (all_up) begin
                    state_d = ST_LINKED;
                    retry_d = '0;
                    go      = 1'b1;
                end else if (timer_q == TW'(LINK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RW'(MAX_RETRIES) || !AUTO_RETRY_EN) ? ST_FAILED : ST_BACKOFF;
                    go      = 1'b1;
                end
                ST_LINKED: if (hard_s || (!ch_s && down_q)) begin
                    state_d = ST_BACKOFF;
                    drop_d  = (&drop_q) ? drop_q : drop_q + 1'b1;
                    go      = 1'b1;
                end
                ST_BACKOFF: if (timer_q == bo_last) begin
                    state_d = ST_PMA_ASSERT;
                    go      = 1'b1;
                end
                default: ;
            endcase
        end
        timer_d    = go ? '0 : ((&timer_q) ? timer_q : timer_q + 1'b1);
        down_d     = (state_q == ST_LINKED) && !ch_s && !go;
        pma_prev_d = pma_s;
        pma_d      = (state_d == ST_PMA_ASSERT) || (state_d == ST_FAILED);
        rpb_d      = !((state_d == ST_WAIT_UP) || (state_d == ST_LINKED));
        ok_d       = state_d == ST_LINKED;
        fail_d     = state_d == ST_FAILED;
    end

    always_ff @(posedge INIT_CLK_IN or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_PMA_ASSERT;
            timer_q    <= '0;
            retry_q    <= '0;
            drop_q     <= '0;
            down_q     <= 1'b0;
            pma_prev_q <= 1'b0;
            pma_q      <= 1'b1;
            rpb_q      <= 1'b1;
            ok_q       <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            drop_q     <= drop_d;
            down_q     <= down_d;
            pma_prev_q <= pma_prev_d;
            pma_q      <= pma_d;
            rpb_q      <= rpb_d;
            ok_q       <= ok_d;
            fail_q     <= fail_d;
        end
    end

    assign pma_init_o  = pma_q;
    assign reset_pb_o  = rpb_q;
    assign link_ok     = ok_q;
    assign link_failed = fail_q;
    assign retry_cnt   = retry_q;
    assign drop_cnt    = drop_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_aurora_link_init_ctrl.sv
// tb_aurora_link_init_ctrl: directed scenarios; expected state entries are queued by the
// stimulus and popped by a monitor on every observed state change.
module tb_aurora_link_init_ctrl;
    localparam logic [2:0] S_PMA = 3'd0, S_HOLD = 3'd1, S_WAIT = 3'd2,
                           S_LINK = 3'd3, S_BO = 3'd4, S_FAIL = 3'd5;

    logic        clk = 1'b0;
    logic        RESET_N, PMA_INIT, CHANNEL_UP, HARD_ERR, AUTO_RETRY_EN;
    logic [3:0]  LANE_UP;
    logic        pma_init_o, reset_pb_o, link_ok, link_failed;
    logic [1:0]  retry_cnt;
    logic [15:0] drop_cnt;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    aurora_link_init_ctrl #(
        .N_LANES(4), .PMA_PULSE_CYCLES(8), .RESET_PB_HOLD(4), .LINK_TIMEOUT(32),
        .MAX_RETRIES(2), .BACKOFF_BASE(4), .SYNC_STAGES(2)
    ) dut (
        .INIT_CLK_IN(clk), .RESET_N(RESET_N), .PMA_INIT(PMA_INIT), .CHANNEL_UP(CHANNEL_UP),
        .LANE_UP(LANE_UP), .HARD_ERR(HARD_ERR), .AUTO_RETRY_EN(AUTO_RETRY_EN),
        .pma_init_o(pma_init_o), .reset_pb_o(reset_pb_o), .link_ok(link_ok),
        .link_failed(link_failed), .retry_cnt(retry_cnt), .drop_cnt(drop_cnt), .state_o(state_o)
    );

    typedef struct {
        logic [2:0] st;
        int         retry;
        int         drop;
        int         dur;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // dur = cycles the previous state is expected to have lasted; 0 means unchecked.
    task automatic push(input logic [2:0] st, input int retry, input int drop, input int dur);
        exp_q.push_back('{st, retry, drop, dur});
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected transitions outstanding after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        @(negedge clk);
        while (state_o != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (state_o != st) begin
            errors++;
            $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state_o, st, budget);
        end
    endtask

    initial begin : monitor
        logic [2:0] prev;
        int         in_cnt;
        exp_t       e;
        prev   = S_PMA;
        in_cnt = 0;
        forever begin
            @(negedge clk);
            if (!RESET_N) begin
                prev   = state_o;
                in_cnt = 0;
            end else if (state_o != prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transition: %0d -> %0d, none expected", prev, state_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("state", int'(state_o), int'(e.st));
                    chk("pma_init_o", int'(pma_init_o), int'(e.st == S_PMA || e.st == S_FAIL));
                    chk("reset_pb_o", int'(reset_pb_o), int'(!(e.st == S_WAIT || e.st == S_LINK)));
                    chk("link_ok", int'(link_ok), int'(e.st == S_LINK));
                    chk("link_failed", int'(link_failed), int'(e.st == S_FAIL));
                    chk("retry_cnt", int'(retry_cnt), e.retry);
                    chk("drop_cnt", int'(drop_cnt), e.drop);
                    if (e.dur != 0) chk("prev_state_cycles", in_cnt, e.dur);
                end
                prev   = state_o;
                in_cnt = 1;
            end else begin
                in_cnt++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b1; PMA_INIT = 1'b0; CHANNEL_UP = 1'b0; HARD_ERR = 1'b0;
        LANE_UP = 4'h0; AUTO_RETRY_EN = 1'b1;
        #1 RESET_N = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state_o), int'(S_PMA));
        chk("rst_pma_init", int'(pma_init_o), 1);
        chk("rst_reset_pb", int'(reset_pb_o), 1);
        chk("rst_link_ok", int'(link_ok), 0);
        chk("rst_link_failed", int'(link_failed), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        // Power-up: pulse includes the reset-release synchroniser latency.
        push(S_HOLD, 0, 0, 10);
        push(S_WAIT, 0, 0, 4);
        push(S_LINK, 0, 0, 1);
        @(posedge clk); #2 RESET_N = 1'b1;
        repeat (5) @(posedge clk);
        #2 CHANNEL_UP = 1'b1; LANE_UP = 4'hF;
        wait_drain(300);

        // Single-cycle CHANNEL_UP dropout must not leave LINKED.
        repeat (3) @(posedge clk);
        #2 CHANNEL_UP = 1'b0;
        @(posedge clk); #2 CHANNEL_UP = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("glitch_state", int'(state_o), int'(S_LINK));
        chk("glitch_link_ok", int'(link_ok), 1);

        // Hard error recovers through BACKOFF with base length.
        push(S_BO, 0, 1, 0);
        push(S_PMA, 0, 1, 4);
        push(S_HOLD, 0, 1, 8);
        push(S_WAIT, 0, 1, 4);
        push(S_LINK, 0, 1, 1);
        @(posedge clk); #2 HARD_ERR = 1'b1;
        repeat (3) @(posedge clk);
        #2 HARD_ERR = 1'b0;
        wait_drain(300);

        // Channel lost for good: two timeouts, doubled backoff, then FAILED.
        push(S_BO, 0, 2, 0);
        push(S_PMA, 0, 2, 4);
        push(S_HOLD, 0, 2, 8);
        push(S_WAIT, 0, 2, 4);
        push(S_BO, 1, 2, 32);
        push(S_PMA, 1, 2, 8);
        push(S_HOLD, 1, 2, 8);
        push(S_WAIT, 1, 2, 4);
        push(S_FAIL, 2, 2, 32);
        @(posedge clk); #2 CHANNEL_UP = 1'b0;
        wait_drain(400);
        repeat (10) @(posedge clk);
        #1;
        chk("failed_state", int'(state_o), int'(S_FAIL));
        chk("failed_pma_init", int'(pma_init_o), 1);
        chk("failed_reset_pb", int'(reset_pb_o), 1);

        // Manual request leaves FAILED; later one collides with a timeout and wins.
        push(S_PMA, 0, 2, 0);
        push(S_HOLD, 0, 2, 8);
        push(S_WAIT, 0, 2, 4);
        push(S_BO, 1, 2, 32);
        push(S_PMA, 1, 2, 8);
        push(S_HOLD, 1, 2, 8);
        push(S_WAIT, 1, 2, 4);
        push(S_PMA, 0, 2, 32);
        push(S_HOLD, 0, 2, 8);
        @(posedge clk); #2 PMA_INIT = 1'b1;
        repeat (3) @(posedge clk);
        #2 PMA_INIT = 1'b0;
        wait_state(S_BO, 200);
        wait_state(S_WAIT, 200);
        repeat (29) @(posedge clk);
        #2 PMA_INIT = 1'b1;
        repeat (3) @(posedge clk);
        #2 PMA_INIT = 1'b0;
        wait_state(S_HOLD, 200);
        wait_drain(50);

        // Asynchronous reset in RESET_HOLD, then a no-retry failure.
        repeat (2) @(posedge clk);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_state", int'(state_o), int'(S_PMA));
        chk("async_rst_pma_init", int'(pma_init_o), 1);
        chk("async_rst_reset_pb", int'(reset_pb_o), 1);
        chk("async_rst_link_ok", int'(link_ok), 0);
        chk("async_rst_link_failed", int'(link_failed), 0);
        chk("async_rst_retry", int'(retry_cnt), 0);
        chk("async_rst_drop", int'(drop_cnt), 0);
        AUTO_RETRY_EN = 1'b0;
        push(S_HOLD, 0, 0, 10);
        push(S_WAIT, 0, 0, 4);
        push(S_FAIL, 1, 0, 32);
        repeat (2) @(posedge clk);
        #2 RESET_N = 1'b1;
        wait_drain(300);
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
